// File: rtl/eb_wb_ram_slave.sv
// eb_wb_ram_slave: pipelined Wishbone slave RAM for the Etherbone master port.
// Byte-lane writes, fixed read latency of g_latency cycles, error response
// for addresses above the implemented depth, and squashing of in-flight
// responses when the master drops cyc_i.
// Optional build macro EB_RAM_STALL_EN: adds a seeded 16-bit LFSR that
// stalls the bus on roughly one cycle in sixteen.
module eb_wb_ram_slave #(
  parameter int unsigned g_addr_width = 10,
  parameter int unsigned g_latency    = 1,
  parameter logic [15:0] g_lfsr_seed  = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        nRst_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        stall_o
);

  localparam int unsigned DEPTH = 2 ** g_addr_width;

  logic [31:0]             mem [DEPTH];
  logic                    acc;
  logic                    in_range;
  logic [g_addr_width-1:0] idx;
  logic [31:0]             rd_word;

  // Inputs of each response stage; index 0 is the request being accepted now.
  logic                    ack_p [g_latency];
  logic                    err_p [g_latency];
  logic [31:0]             dat_p [g_latency];

  assign acc      = cyc_i & stb_i & ~stall_o;
  assign in_range = (adr_i[31:g_addr_width] == '0);
  assign idx      = adr_i[g_addr_width-1:0];
  // Out-of-range slots carry zero data.
  assign rd_word  = in_range ? mem[idx] : 32'd0;

  assign ack_p[0] = acc & in_range;
  assign err_p[0] = acc & ~in_range;
  assign dat_p[0] = rd_word;

  // Byte-lane RAM write; the read above sees the old word on the same edge.
  always_ff @(posedge clk_i) begin
    if (acc && we_i && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_i[b]) mem[idx][8*b +: 8] <= dat_i[8*b +: 8];
      end
    end
  end

  // Intermediate response stages (none when g_latency is 1).
  for (genvar i = 1; i < g_latency; i++) begin : g_stage
    logic        ack_q;
    logic        err_q;
    logic [31:0] dat_q;

    // Stage control: cleared by reset and squashed whenever cyc_i is low.
    always_ff @(posedge clk_i or negedge nRst_i) begin
      if (!nRst_i) begin
        ack_q <= 1'b0;
        err_q <= 1'b0;
      end else if (!cyc_i) begin
        ack_q <= 1'b0;
        err_q <= 1'b0;
      end else begin
        ack_q <= ack_p[i-1];
        err_q <= err_p[i-1];
      end
    end

    // Stage data: only meaningful alongside ack_q, so no reset.
    always_ff @(posedge clk_i) begin
      dat_q <= dat_p[i-1];
    end

    assign ack_p[i] = ack_q;
    assign err_p[i] = err_q;
    assign dat_p[i] = dat_q;
  end

  // Last stage drives the registered bus outputs; dat_o is zero unless acking.
  always_ff @(posedge clk_i or negedge nRst_i) begin
    if (!nRst_i) begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      dat_o <= 32'd0;
    end else if (!cyc_i) begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      dat_o <= 32'd0;
    end else begin
      ack_o <= ack_p[g_latency-1];
      err_o <= err_p[g_latency-1];
      dat_o <= ack_p[g_latency-1] ? dat_p[g_latency-1] : 32'd0;
    end
  end

`ifdef EB_RAM_STALL_EN
  logic [15:0] lfsr;
  logic [15:0] lfsr_nxt;

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward the MSB.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  assign lfsr_nxt = lfsr_step(lfsr);

  // Free-running LFSR; stall is registered from the state being loaded.
  always_ff @(posedge clk_i or negedge nRst_i) begin
    if (!nRst_i) begin
      lfsr    <= g_lfsr_seed;
      stall_o <= 1'b0;
    end else begin
      lfsr    <= lfsr_nxt;
      stall_o <= (lfsr_nxt[3:0] == 4'd0);
    end
  end
`else
  logic [15:0] lfsr_seed_unused;

  assign lfsr_seed_unused = g_lfsr_seed;
  assign stall_o          = 1'b0;
`endif

endmodule

// File: tb/tb_eb_wb_ram_slave.sv
// Scoreboard bench for eb_wb_ram_slave (g_latency=3, g_addr_width=10).
// Accepted requests push an expected response; responses pop and compare.
module tb_eb_wb_ram_slave;

  localparam int          AW   = 10;
  localparam int          LAT  = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk_i  = 1'b0;
  logic        nRst_i = 1'b0;
  logic        cyc_i  = 1'b0;
  logic        stb_i  = 1'b0;
  logic        we_i   = 1'b0;
  logic [3:0]  sel_i  = 4'h0;
  logic [31:0] adr_i  = 32'd0;
  logic [31:0] dat_i  = 32'd0;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        err_o;
  logic        stall_o;

  eb_wb_ram_slave #(
    .g_addr_width(AW),
    .g_latency   (LAT),
    .g_lfsr_seed (SEED)
  ) dut (
    .clk_i  (clk_i),
    .nRst_i (nRst_i),
    .cyc_i  (cyc_i),
    .stb_i  (stb_i),
    .we_i   (we_i),
    .sel_i  (sel_i),
    .adr_i  (adr_i),
    .dat_i  (dat_i),
    .dat_o  (dat_o),
    .ack_o  (ack_o),
    .err_o  (err_o),
    .stall_o(stall_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        err;
    logic        known;
    logic [31:0] dat;
    int          cyc;
  } rsp_t;

  rsp_t        sbq [$];
  logic [31:0] mdl_mem   [1024];
  bit          mdl_known [1024];
  int          cyc_cnt = 0;
  int          rsp_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] last_dat = 32'd0;
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

`ifdef EB_RAM_STALL_EN
  logic [15:0] lfsr_m;
  logic        stall_m;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  always @(posedge clk_i or negedge nRst_i) begin
    if (!nRst_i) begin
      lfsr_m  <= SEED;
      stall_m <= 1'b0;
    end else begin
      lfsr_m  <= lfsr_next(lfsr_m);
      stall_m <= ((lfsr_next(lfsr_m) & 16'h000F) == 16'h0000);
    end
  end
`endif

  // Monitor: mid-cycle sampling of responses, accepts, aborts and stall.
  initial begin
    rsp_t e;
    int   idx;
    bit   inr;
    forever begin
      @(negedge clk_i);
`ifdef EB_RAM_STALL_EN
      check("stall_lfsr", 32'(stall_o), 32'(stall_m));
`else
      check("stall_zero", 32'(stall_o), 32'd0);
`endif
      if (!nRst_i) begin
        sbq.delete();
      end else begin
        if (ack_o || err_o) begin
          rsp_cnt++;
          if (err_o) err_cnt++;
          if (ack_o) last_dat = dat_o;
          check("ack_err_excl", 32'(ack_o & err_o), 32'd0);
          if (sbq.size() == 0) begin
            check("unexpected_rsp", 32'd1, 32'd0);
          end else begin
            e = sbq.pop_front();
            check("rsp_is_err", 32'(err_o), 32'(e.err));
            check("rsp_latency", 32'(cyc_cnt - e.cyc), 32'(LAT));
            if (e.known) check("rsp_data", dat_o, e.dat);
          end
        end
        if (cyc_i && stb_i && !stall_o) begin
          idx     = int'(adr_i[AW-1:0]);
          inr     = (adr_i[31:AW] == '0);
          e.err   = !inr;
          e.cyc   = cyc_cnt;
          e.known = inr ? mdl_known[idx] : 1'b1;
          e.dat   = inr ? mdl_mem[idx] : 32'd0;
          sbq.push_back(e);
          if (inr && we_i) begin
            for (int b = 0; b < 4; b++) begin
              if (sel_i[b]) mdl_mem[idx][8*b +: 8] = dat_i[8*b +: 8];
            end
            if (sel_i == 4'hF) mdl_known[idx] = 1'b1;
          end
        end
        if (!cyc_i) sbq.delete();
      end
    end
  end

  // One request, held until a non-stalled cycle; returns just after its accept edge.
  task automatic req(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                     input logic [31:0] dat);
    int g;
    stb_i = 1'b1;
    we_i  = we;
    adr_i = adr;
    sel_i = sel;
    dat_i = dat;
    g = 0;
    @(negedge clk_i);
    while (stall_o && g < 64) begin
      @(negedge clk_i);
      g++;
    end
    if (g >= 64) check("stall_timeout", 32'd1, 32'd0);
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    int g;
    stb_i = 1'b0;
    g = 0;
    while (sbq.size() != 0 && g < 40) begin
      @(posedge clk_i);
      #1;
      g++;
    end
    if (sbq.size() != 0) check("drain_timeout", 32'(sbq.size()), 32'd0);
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int e0;
    int ra [100];

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_ack", 32'(ack_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_dat", dat_o, 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    @(posedge clk_i);
    #1 nRst_i = 1'b1;
    wait_cycles(1);
    cyc_i = 1'b1;

    // write then read
    req(1'b1, 32'd5, 4'hF, 32'hDEADBEEF);
    req(1'b0, 32'd5, 4'hF, 32'd0);
    drain();
    check("wr_rd_dat", last_dat, 32'hDEADBEEF);

    // byte lanes
    req(1'b1, 32'd7, 4'hF, 32'h11223344);
    req(1'b1, 32'd7, 4'b0101, 32'hAABBCCDD);
    req(1'b0, 32'd7, 4'hF, 32'd0);
    drain();
    check("byte_lanes", last_dat, 32'h11BB33DD);

    // back-to-back pipelined reads
    for (int i = 0; i < 8; i++) req(1'b1, 32'(i), 4'hF, 32'(i));
    drain();
    r0 = rsp_cnt;
    for (int i = 0; i < 8; i++) req(1'b0, 32'(i), 4'h0, 32'd0);
    drain();
    check("pipe_rsp_cnt", 32'(rsp_cnt - r0), 32'd8);
    check("pipe_last", last_dat, 32'd7);

    // out-of-range read and write
    e0 = err_cnt;
    req(1'b0, 32'h400, 4'hF, 32'd0);
    drain();
    check("range_err_cnt", 32'(err_cnt - e0), 32'd1);
    req(1'b1, 32'h400, 4'hF, 32'hFFFFFFFF);
    req(1'b0, 32'd0, 4'hF, 32'd0);
    drain();
    check("range_mem0", last_dat, 32'd0);

    // abort with reads in flight
    req(1'b0, 32'd1, 4'hF, 32'd0);
    req(1'b0, 32'd2, 4'hF, 32'd0);
    req(1'b0, 32'd3, 4'hF, 32'd0);
    cyc_i = 1'b0;
    stb_i = 1'b0;
    wait_cycles(1);
    r0 = rsp_cnt;
    wait_cycles(8);
    check("abort_no_rsp", 32'(rsp_cnt - r0), 32'd0);

    // abort after a write: the write still lands
    cyc_i = 1'b1;
    req(1'b1, 32'd2, 4'hF, 32'h12345678);
    cyc_i = 1'b0;
    stb_i = 1'b0;
    wait_cycles(6);
    cyc_i = 1'b1;
    req(1'b0, 32'd2, 4'hF, 32'd0);
    drain();
    check("abort_wr_kept", last_dat, 32'h12345678);

    // reset with a response pending
    req(1'b0, 32'd5, 4'hF, 32'd0);
    stb_i  = 1'b0;
    nRst_i = 1'b0;
    #1;
    check("midrst_ack", 32'(ack_o), 32'd0);
    wait_cycles(2);
    nRst_i = 1'b1;
    r0 = rsp_cnt;
    wait_cycles(8);
    check("midrst_no_rsp", 32'(rsp_cnt - r0), 32'd0);

    // random writes then readbacks, honouring stall
    for (int i = 0; i < 100; i++) begin
      ra[i] = int'($urandom_range(0, 1023));
      req(1'b1, 32'(ra[i]), 4'hF, $urandom);
    end
    for (int i = 0; i < 100; i++) req(1'b0, 32'(ra[i]), 4'hF, 32'd0);
    drain();

    check("sb_empty", 32'(sbq.size()), 32'd0);
    cyc_i = 1'b0;
    wait_cycles(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eb_wb_ram_slave.md
Name: eb_wb_ram_slave

Overview:
Pipelined Wishbone slave RAM that consumes the master port of the Etherbone core (master_cyc_o/stb_o/we_o/sel_o/adr_o/dat_o) and returns dat/ack/err/stall. It is the synthesizable replacement for the behavioural memory used in EB_CORE simulation and on-chip test targets. It has byte-lane writes, a configurable fixed read latency, out-of-range error signalling and cycle-abort squashing.

Parameters:
g_addr_width, 10, word-address bits implemented; depth = 2**g_addr_width 32-bit words.
g_latency, 1, cycles from request acceptance to ack/err; legal 1..4.
g_lfsr_seed, 16'hACE1, initial LFSR value; used only with EB_RAM_STALL_EN.

Ports:
clk_i  in  1  system clock; all logic on the rising edge.
nRst_i  in  1  reset, asynchronous, active-low.
cyc_i  in  1  Wishbone cycle.
stb_i  in  1  Wishbone strobe.
we_i  in  1  write enable.
sel_i  in  4  byte selects; sel_i[0] = dat[7:0].
adr_i  in  32  word address; bits [g_addr_width-1:0] index the RAM.
dat_i  in  32  write data.
dat_o  out  32  read data, valid when ack_o=1.
ack_o  out  1  one pulse per accepted, in-range request.
err_o  out  1  one pulse per accepted, out-of-range request.
stall_o  out  1  request not accepted this cycle.

Behaviour:
- Reset (async assert, sync release): ack_o=0, err_o=0, dat_o=0, stall_o=0, response pipeline cleared. With EB_RAM_STALL_EN, LFSR=g_lfsr_seed. RAM contents are not reset.
- Accept condition: cyc_i & stb_i & ~stall_o, sampled on the rising edge. One request per cycle at most. Back-to-back requests are accepted at full rate.
- Range check: adr_i[31:g_addr_width] != 0 -> out of range. An out-of-range request is accepted but does not touch the RAM; it produces err_o instead of ack_o. dat_o=0 for that slot.
- Write: on the accept edge, for each i with sel_i[i]=1, byte i of mem[adr] is updated from dat_i byte i. sel_i=0 writes nothing but is still acked. Write ack follows after g_latency cycles; dat_o in that slot is the pre-write word.
- Read: mem[adr] is captured on the accept edge; the value is read-before-write relative to any write in the same cycle. A read accepted the cycle after a write to the same address returns the new data. sel_i is ignored for reads; all 32 bits are returned.
- Response pipeline: g_latency-stage shift register carrying {valid, err, data}. ack_o/err_o/dat_o are registered outputs of the last stage. Responses leave in request order, exactly g_latency cycles after their accept edge, with no gaps inserted.
- Cycle abort: if cyc_i=0 at any edge, all in-flight stages are invalidated at that edge. No ack/err is emitted for them afterwards. Writes already performed remain.
- ack_o and err_o are never both 1. Neither output is asserted while cyc_i is low on the same edge that squashes them.
- Without EB_RAM_STALL_EN, stall_o is constant 0.
- Reset mid-cycle: pending responses are lost immediately; no ack/err after nRst_i rises until a new request is accepted.

Optional Feature:
EB_RAM_STALL_EN
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every clock. stall_o is registered and = 1 when the next LFSR state [3:0] == 0 (about 1/16 of cycles). A stalled request is not accepted, has no RAM effect and is retried by the master. This exercises the EB_CORE master_stall_i path deterministically from the seed.
- Undefined: the LFSR is not present and stall_o is tied 0.

Test Plan:
- Write then read, g_latency=1: write adr 5 dat 32'hDEADBEEF sel 4'hF, then read adr 5 -> ack exactly 1 cycle after each accept; read dat_o=32'hDEADBEEF.
- Byte lanes: preload adr 7 = 32'h11223344; write dat 32'hAABBCCDD sel 4'b0101; read adr 7 -> 32'h11BB33DD.
- Pipelining, g_latency=3: 8 back-to-back reads of adr 0..7, each word preloaded as its own address -> 8 consecutive ack cycles starting 3 cycles after the first accept, dat_o = 0..7 in order.
- Range error, g_addr_width=10: read adr 32'h400 -> err_o=1, ack_o=0, dat_o=0; a following write to adr 32'h400 leaves mem[0] unchanged.
- Abort: g_latency=4; issue 3 reads, drop cyc_i 2 cycles after the first accept -> zero acks; write adr 2 then abort -> mem[2] is still updated.
- EB_RAM_STALL_EN: 100 random writes then 100 readbacks with the master honouring stall -> all data match; the observed stall cycles match the LFSR model computed from g_lfsr_seed.
